// File: rtl/card_shoe.sv
// 52-card shoe dealing random undealt cards, picked with a free-running 16-bit LFSR.
// Optional CARD_SHOE_SEED_EN adds i_seed_load/i_seed to reseed the LFSR.
module card_shoe #(
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_request,
  input  logic       i_shuffle,
`ifdef CARD_SHOE_SEED_EN
  input  logic       i_seed_load,
  input  logic [15:0] i_seed,
`endif
  output logic       o_valid,
  output logic [3:0] o_rank,
  output logic [1:0] o_suit,
  output logic [3:0] o_value,
  output logic [5:0] o_remaining,
  output logic       o_busy,
  output logic       o_reshuffled
);

  typedef enum logic [1:0] {StIdle, StPick, StScan, StDeliver} state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [51:0] mask_q, mask_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  remaining_q, remaining_d;
  logic [3:0]  rank_q, rank_d;
  logic [1:0]  suit_q, suit_d;
  logic [3:0]  value_q, value_d;
  logic        reshuffle;

  logic        lfsr_fb;
  logic [5:0]  pick;
  logic [5:0]  rank_full;
  logic [3:0]  rank_c;
  logic [1:0]  suit_c;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign pick    = lfsr_q[5:0];

  // Card index -> rank/suit without a divider: idx = suit*13 + rank-1.
  always_comb begin
    suit_c    = 2'd0;
    rank_full = 6'd0;
    if (idx_q < 6'd13) begin
      suit_c    = 2'd0;
      rank_full = idx_q + 6'd1;
    end else if (idx_q < 6'd26) begin
      suit_c    = 2'd1;
      rank_full = idx_q - 6'd12;
    end else if (idx_q < 6'd39) begin
      suit_c    = 2'd2;
      rank_full = idx_q - 6'd25;
    end else begin
      suit_c    = 2'd3;
      rank_full = idx_q - 6'd38;
    end
    rank_c = rank_full[3:0];
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    rank_d      = rank_q;
    suit_d      = suit_q;
    value_d     = value_q;
    reshuffle   = 1'b0;
    lfsr_d      = {lfsr_q[14:0], lfsr_fb};
`ifdef CARD_SHOE_SEED_EN
    if (i_seed_load) begin
      lfsr_d = (i_seed == 16'd0) ? LFSR_INIT : i_seed;
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (i_shuffle) begin
          mask_d      = '0;
          remaining_d = 6'd52;
        end
        if (i_request) begin
          // An explicit shuffle in the same cycle already refills the shoe.
          if (!i_shuffle && remaining_q == 6'd0) begin
            mask_d      = '0;
            remaining_d = 6'd52;
            reshuffle   = 1'b1;
          end
          state_d = StPick;
        end
      end
      StPick: begin
        idx_d   = (pick >= 6'd52) ? pick - 6'd52 : pick;
        state_d = StScan;
      end
      StScan: begin
        if (!mask_q[idx_q]) begin
          rank_d  = rank_c;
          suit_d  = suit_c;
          value_d = (rank_c > 4'd10) ? 4'd10 : rank_c;
          state_d = StDeliver;
        end else begin
          idx_d = (idx_q == 6'd51) ? 6'd0 : idx_q + 6'd1;
        end
      end
      StDeliver: begin
        mask_d[idx_q] = 1'b1;
        remaining_d   = remaining_q - 6'd1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      lfsr_q      <= LFSR_INIT;
      mask_q      <= '0;
      idx_q       <= 6'd0;
      remaining_q <= 6'd52;
      rank_q      <= 4'd0;
      suit_q      <= 2'd0;
      value_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      rank_q      <= rank_d;
      suit_q      <= suit_d;
      value_q     <= value_d;
    end
  end

  assign o_valid      = (state_q == StDeliver);
  assign o_busy       = (state_q != StIdle);
  assign o_reshuffled = reshuffle;
  assign o_rank       = rank_q;
  assign o_suit       = suit_q;
  assign o_value      = value_q;
  assign o_remaining  = remaining_q;

  // A card may never be handed out twice before a refill.
  a_no_double_deal : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (state_q == StDeliver) |-> !mask_q[idx_q]);

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: vector table, directed corner cases and a random
// sequence checked against a set-based model of the shoe.
module tb_card_shoe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       sh;
  logic       o_valid;
  logic [3:0] o_rank;
  logic [1:0] o_suit;
  logic [3:0] o_value;
  logic [5:0] o_remaining;
  logic       o_busy;
  logic       o_reshuffled;
`ifdef CARD_SHOE_SEED_EN
  logic        seed_load;
  logic [15:0] seed;
  bit          pend_seed = 1'b0;
  logic [15:0] pend_seed_val = 16'd0;
`endif

  card_shoe dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_request   (req),
    .i_shuffle   (sh),
`ifdef CARD_SHOE_SEED_EN
    .i_seed_load (seed_load),
    .i_seed      (seed),
`endif
    .o_valid     (o_valid),
    .o_rank      (o_rank),
    .o_suit      (o_suit),
    .o_value     (o_value),
    .o_remaining (o_remaining),
    .o_busy      (o_busy),
    .o_reshuffled(o_reshuffled)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  int valid_cnt      = 0;
  int resh_cnt       = 0;
  int last_valid_cyc = -1000;
  int min_gap        = 1000;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_valid === 1'b1) begin
        if (cyc - last_valid_cyc < min_gap) min_gap = cyc - last_valid_cyc;
        last_valid_cyc = cyc;
        valid_cnt++;
      end
      if (o_reshuffled === 1'b1) resh_cnt++;
    end
  end

  // Model: which cards are out of the shoe, and how many remain.
  bit         dealt[52];
  int         model_rem;
  logic [3:0] last_rank;
  logic [1:0] last_suit;
  logic [3:0] last_value;
  int         last_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_refill();
    for (int i = 0; i < 52; i++) dealt[i] = 1'b0;
    model_rem = 52;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req   = 1'b0;
    sh    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_refill();
  endtask

  // One request (optionally with a simultaneous shuffle); checks the dealt card.
  task automatic deal(input bit with_shuffle, input string tag);
    bit got;
    bit resh;
    bit exp_resh;
    int lat;
    int idx;
    logic [3:0] r;
    logic [1:0] s;
    logic [3:0] v;
    got = 1'b0;
    lat = 0;
    r = 4'd0; s = 2'd0; v = 4'd0;
    @(posedge clk); #1;
    req = 1'b1;
    sh  = with_shuffle;
`ifdef CARD_SHOE_SEED_EN
    seed_load = pend_seed;
    seed      = pend_seed_val;
`endif
    if (with_shuffle) model_refill();
    exp_resh = (model_rem == 0);
    if (exp_resh) model_refill();
    @(negedge clk);
    resh = o_reshuffled;
    check({tag, "_idle"}, o_busy, 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
    sh  = 1'b0;
`ifdef CARD_SHOE_SEED_EN
    seed_load = 1'b0;
    pend_seed = 1'b0;
`endif
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        got = 1'b1;
        lat = k;
        r = o_rank; s = o_suit; v = o_value;
      end
    end
    check({tag, "_resh"}, resh, exp_resh);
    check({tag, "_valid_seen"}, got, 1'b1);
    last_lat = lat;
    if (got) begin
      check({tag, "_latency_in_3_54"}, (lat >= 3 && lat <= 54), 1'b1);
      check({tag, "_rank_range"}, (r >= 1 && r <= 13), 1'b1);
      check({tag, "_value"}, v, (r > 10) ? 4'd10 : r);
      idx = int'(s) * 13 + int'(r) - 1;
      if (idx >= 0 && idx < 52) begin
        check({tag, "_card_undealt"}, dealt[idx], 1'b0);
        dealt[idx] = 1'b1;
      end
      model_rem--;
      last_rank = r; last_suit = s; last_value = v;
      @(posedge clk); #1;
      check({tag, "_remaining"}, o_remaining, model_rem);
      check({tag, "_hold_card"}, {o_suit, o_rank, o_value}, {s, r, v});
    end
  endtask

  task automatic shuffle_only();
    @(posedge clk); #1 sh = 1'b1;
    @(posedge clk); #1 sh = 1'b0;
    model_refill();
    @(negedge clk);
    check("shuffle_remaining", o_remaining, 6'd52);
    check("shuffle_no_resh", o_reshuffled, 1'b0);
  endtask

  typedef struct {
    bit req;
    bit sh;
    bit busy;
    bit valid;
    bit resh;
    int rem;
  } vec_t;

  vec_t tbl[12];
  int   vc;

  initial begin
    // Expected values describe outputs during the cycle the inputs are applied.
    tbl[0]  = '{0, 0, 0, 0, 0, 52};
    tbl[1]  = '{1, 0, 0, 0, 0, 52};
    tbl[2]  = '{0, 0, 1, 0, 0, 52};
    tbl[3]  = '{0, 0, 1, 0, 0, 52};
    tbl[4]  = '{0, 0, 1, 1, 0, 52};
    tbl[5]  = '{0, 0, 0, 0, 0, 51};
    tbl[6]  = '{1, 1, 0, 0, 0, 51};
    tbl[7]  = '{1, 0, 1, 0, 0, 52};
    tbl[8]  = '{0, 0, 1, 0, 0, 52};
    tbl[9]  = '{0, 0, 1, 1, 0, 52};
    tbl[10] = '{0, 1, 0, 0, 0, 51};
    tbl[11] = '{0, 0, 0, 0, 0, 52};

    rst_n = 1'b0;
    req   = 1'b0;
    sh    = 1'b0;
`ifdef CARD_SHOE_SEED_EN
    seed_load = 1'b0;
    seed      = 16'd0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {o_valid, o_busy, o_reshuffled, o_remaining, o_rank, o_suit, o_value},
          {1'b0, 1'b0, 1'b0, 6'd52, 4'd0, 2'd0, 4'd0});
    @(posedge clk); #1 rst_n = 1'b1;
    model_refill();

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      req = tbl[i].req;
      sh  = tbl[i].sh;
      @(negedge clk);
      check($sformatf("vec%0d", i), {o_busy, o_valid, o_reshuffled, o_remaining},
            {tbl[i].busy, tbl[i].valid, tbl[i].resh, 6'(tbl[i].rem)});
    end
    req = 1'b0;
    sh  = 1'b0;

    // Whole shoe from reset, then the automatic refill.
    do_reset();
    vc = resh_cnt;
    for (int i = 0; i < 52; i++) deal(1'b0, $sformatf("full%0d", i));
    check("full_no_resh", resh_cnt - vc, 0);
    deal(1'b0, "refill");
    check("refill_latency", last_lat, 3);
    check("refill_resh_count", resh_cnt - vc, 1);

    // Shuffle together with a request after 10 deals.
    do_reset();
    for (int i = 0; i < 10; i++) deal(1'b0, $sformatf("pre%0d", i));
    vc = resh_cnt;
    deal(1'b1, "shreq");
    check("shreq_no_resh", resh_cnt - vc, 0);
    check("shreq_remaining", o_remaining, 6'd51);

    // Requests pulsed while busy are dropped.
    vc = valid_cnt;
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    repeat (70) @(posedge clk);
    check("busy_pulse_one_deal", valid_cnt - vc, 1);
    shuffle_only();

    // Request held high: repeated deals spaced by at least 4 cycles.
    vc = valid_cnt;
    min_gap = 1000;
    @(posedge clk); #1 req = 1'b1;
    repeat (10) @(posedge clk);
    #1 req = 1'b0;
    repeat (70) @(posedge clk);
    check("held_multi_deal", (valid_cnt - vc) >= 2, 1'b1);
    check("held_gap_ge4", min_gap >= 4, 1'b1);
    shuffle_only();

    // Reset during SCAN.
    do_reset();
    for (int i = 0; i < 3; i++) deal(1'b0, $sformatf("rs%0d", i));
    vc = valid_cnt;
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("rst_scan_busy", o_busy, 1'b0);
    check("rst_scan_remaining", o_remaining, 6'd52);
    check("rst_scan_valid", o_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_refill();
    repeat (10) @(posedge clk);
    check("rst_scan_no_strobe", valid_cnt - vc, 0);

`ifdef CARD_SHOE_SEED_EN
    // Seeded pick of index 51 twice: second one must wrap to index 0.
    do_reset();
    pend_seed = 1'b1;
    pend_seed_val = 16'h0033;
    deal(1'b0, "seed51");
    check("seed51_card", {last_suit, last_rank, last_value}, {2'd3, 4'd13, 4'd10});
    pend_seed = 1'b1;
    pend_seed_val = 16'h0033;
    deal(1'b0, "seedwrap");
    check("seedwrap_card", {last_suit, last_rank, last_value}, {2'd0, 4'd1, 4'd1});
`endif

    // Random operation mix against the model.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 85) deal(1'b0, $sformatf("rnd%0d", i));
      else if (op < 88) deal(1'b1, $sformatf("rndsh%0d", i));
      else if (op < 92) shuffle_only();
      else repeat ($urandom_range(1, 5)) @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
